// File: rtl/player_fsm_v2_pkg.sv
// Shared definitions for the per-player frame update engine: state codes,
// controller button bit positions and default gameplay tuning values.
package player_fsm_v2_pkg;

  localparam int STATE_DEPTH = 4;
  localparam int INPUT_DEPTH = 5;

  typedef enum logic [STATE_DEPTH-1:0] {
    IDLE    = 4'd0,
    WALK_F  = 4'd1,
    WALK_B  = 4'd2,
    BLOCK   = 4'd3,
    KICK    = 4'd4,
    GRAB    = 4'd5,
    HITSTUN = 4'd6,
    KO      = 4'd7,
    WIN     = 4'd8
  } state_t;

  // Button vector is {WF, WB, G, B, K}
  localparam int BTN_K  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_G  = 2;
  localparam int BTN_WB = 3;
  localparam int BTN_WF = 4;

  localparam int DEF_SCREEN_W      = 640;
  localparam int DEF_PLAYER_W      = 64;
  localparam int DEF_F_SPEED       = 4;
  localparam int DEF_B_SPEED       = 3;
  localparam int DEF_KICK_FRAMES   = 12;
  localparam int DEF_GRAB_FRAMES   = 16;
  localparam int DEF_HITSTUN_FRAMES = 10;
  localparam int DEF_KNOCKBACK     = 6;
  localparam int DEF_MAX_HP        = 100;
  localparam int DEF_DMG_KICK      = 15;
  localparam int DEF_BUF_FRAMES    = 4;

  // Highest-priority pressed button wins: K > B > G > WB > WF > nothing.
  function automatic state_t button_action(input logic [INPUT_DEPTH-1:0] btn);
    if (btn[BTN_K])  return KICK;
    if (btn[BTN_B])  return BLOCK;
    if (btn[BTN_G])  return GRAB;
    if (btn[BTN_WB]) return WALK_B;
    if (btn[BTN_WF]) return WALK_F;
    return IDLE;
  endfunction

endpackage

// File: rtl/player_fsm_v2_if.sv
// Per-player bus: controller/opponent inputs toward the engine and the
// committed player view toward the renderer.
interface player_fsm_v2_if #(
  parameter int POS_W   = 10,
  parameter int TIMER_W = 5,
  parameter int HP_W    = 7
);
  import player_fsm_v2_pkg::*;

  logic [INPUT_DEPTH-1:0] player_buttons;
  logic [POS_W-1:0]       other_player_position;
  logic                   opponent_attack_connected;
  logic                   player_attack_connected;
  logic                   opponent_ko;
  logic [STATE_DEPTH-1:0] state;
  logic [TIMER_W-1:0]     index;
  logic [POS_W-1:0]       position;
  logic [HP_W-1:0]        health;
  logic                   done_gen;

  modport master (
    output player_buttons, other_player_position, opponent_attack_connected,
           player_attack_connected, opponent_ko,
    input  state, index, position, health, done_gen
  );

  modport slave (
    input  player_buttons, other_player_position, opponent_attack_connected,
           player_attack_connected, opponent_ko,
    output state, index, position, health, done_gen
  );
endinterface

// File: rtl/frame_edge_sync.sv
// Brings the frame clock level into sys_clk and flags its rising edge for
// exactly one sys_clk cycle.
module frame_edge_sync (
  input  logic sys_clk,
  input  logic reset,
  input  logic frame_clk,
  output logic frame_rise
);
  logic sync_p0, sync_p1, prev_p2;

  // Two-flop synchronizer followed by a one-cycle history flop
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= frame_clk;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign frame_rise = sync_p1 & ~prev_p2;
endmodule

// File: rtl/player_fsm_v2.sv
// Per-player game-logic engine: one 3-cycle update (latch, compute, commit)
// per frame clock rising edge.
module player_fsm_v2
  import player_fsm_v2_pkg::*;
#(
  parameter int PLAYER_NUM     = 0,
  parameter int POS_W          = 10,
  parameter int SCREEN_W       = DEF_SCREEN_W,
  parameter int PLAYER_W       = DEF_PLAYER_W,
  parameter int START_POS      = 100,
  parameter int F_SPEED        = DEF_F_SPEED,
  parameter int B_SPEED        = DEF_B_SPEED,
  parameter int KICK_FRAMES    = DEF_KICK_FRAMES,
  parameter int GRAB_FRAMES    = DEF_GRAB_FRAMES,
  parameter int HITSTUN_FRAMES = DEF_HITSTUN_FRAMES,
  parameter int KNOCKBACK      = DEF_KNOCKBACK,
  parameter int MAX_HP         = DEF_MAX_HP,
  parameter int DMG_KICK       = DEF_DMG_KICK,
  parameter int BUF_FRAMES     = DEF_BUF_FRAMES,
  parameter int TIMER_W        = 5,
  parameter int HP_W           = 7
) (
  input  logic           sys_clk,
  input  logic           reset,
  input  logic           frame_clk,
  player_fsm_v2_if.slave bus
);
  localparam int X_MAX = SCREEN_W - PLAYER_W - 1;
  localparam int BUF_W = $clog2(BUF_FRAMES + 1);

  function automatic int frame_dur(input state_t s);
    case (s)
      KICK:    return KICK_FRAMES;
      GRAB:    return GRAB_FRAMES;
      HITSTUN: return HITSTUN_FRAMES;
      default: return 1;
    endcase
  endfunction

  function automatic logic [TIMER_W-1:0] timer_step(input state_t s, input logic [TIMER_W-1:0] t);
    if (int'(t) >= frame_dur(s) - 1) return '0;
    return t + 1'b1;
  endfunction

  function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp);
    if (hp >= HP_W'(DMG_KICK)) return hp - HP_W'(DMG_KICK);
    return '0;
  endfunction

  // Signed pixel step for the state entered this frame; left player faces +x.
  function automatic int walk_delta(input state_t s);
    int dir;
    dir = (PLAYER_NUM == 0) ? 1 : -1;
    case (s)
      WALK_F:  return dir * F_SPEED;
      WALK_B:  return -dir * B_SPEED;
      HITSTUN: return -dir * KNOCKBACK;
      default: return 0;
    endcase
  endfunction

  // Move, clamp to the screen, then keep the two sprites from overlapping.
  function automatic logic [POS_W-1:0] place(input logic [POS_W-1:0] pos, input state_t s,
                                             input logic [POS_W-1:0] other);
    int tgt;
    int oth;
    tgt = int'(pos) + walk_delta(s);
    if (tgt < 0) tgt = 0;
    if (tgt > X_MAX) tgt = X_MAX;
    oth = int'(other);
    if (PLAYER_NUM == 0) begin
      if (tgt + PLAYER_W > oth) tgt = (oth > PLAYER_W) ? oth - PLAYER_W : 0;
    end else if (tgt < oth + PLAYER_W) begin
      tgt = oth + PLAYER_W;
    end
    return POS_W'(tgt);
  endfunction

  logic frame_rise;
  logic accept;

  frame_edge_sync u_frame_edge_sync (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .frame_clk (frame_clk),
    .frame_rise(frame_rise)
  );

  // Committed player state
  state_t             state_q;
  logic [TIMER_W-1:0] index_q;
  logic [POS_W-1:0]   pos_q;
  logic [HP_W-1:0]    hp_q;
  state_t             buf_act_q;
  logic [BUF_W-1:0]   buf_cnt_q;
  logic               done_q;

  // Stage 0: inputs sampled at the frame edge
  logic                   vld_p0;
  logic [INPUT_DEPTH-1:0] btn_p0;
  logic [POS_W-1:0]       other_p0;
  logic                   opp_hit_p0;
  logic                   own_hit_p0;
  logic                   opp_ko_p0;

  // Stage 1: staged next values awaiting commit
  logic               vld_p1;
  state_t             state_p1;
  logic [TIMER_W-1:0] index_p1;
  logic [POS_W-1:0]   pos_p1;
  logic [HP_W-1:0]    hp_p1;
  state_t             buf_act_p1;
  logic [BUF_W-1:0]   buf_cnt_p1;

  state_t             state_nx;
  state_t             act_c;
  logic [TIMER_W-1:0] index_nx;
  logic [POS_W-1:0]   pos_nx;
  logic [HP_W-1:0]    hp_nx;
  state_t             buf_act_nx;
  logic [BUF_W-1:0]   buf_cnt_nx;

  // A new frame edge is dropped while an update is still in flight
  assign accept = frame_rise & ~vld_p0 & ~vld_p1;

  // This player's own hit is sampled with the frame but never alters its own update
  logic unused_own_hit;
  assign unused_own_hit = own_hit_p0;

  // Frame resolution: KO/WIN hold, opponent KO, hit, timer hold, then action
  always_comb begin
    state_nx   = state_q;
    index_nx   = index_q;
    hp_nx      = hp_q;
    pos_nx     = pos_q;
    buf_act_nx = buf_act_q;
    buf_cnt_nx = (buf_cnt_q != '0) ? buf_cnt_q - 1'b1 : '0;
    act_c      = IDLE;
    if (state_q == KO || state_q == WIN) begin
      buf_cnt_nx = '0;
    end else begin
      if (opp_ko_p0) begin
        state_nx   = WIN;
        index_nx   = '0;
        buf_cnt_nx = '0;
      end else if (opp_hit_p0 && state_q != BLOCK) begin
        hp_nx      = hp_after_hit(hp_q);
        state_nx   = (hp_nx == '0) ? KO : HITSTUN;
        index_nx   = '0;
        buf_cnt_nx = '0;
      end else if (opp_hit_p0) begin
        index_nx   = '0;
        buf_cnt_nx = '0;
      end else if (int'(index_q) < frame_dur(state_q) - 1) begin
        index_nx = index_q + 1'b1;
        if (btn_p0[BTN_K]) begin
          buf_act_nx = KICK;
          buf_cnt_nx = BUF_W'(BUF_FRAMES);
        end else if (btn_p0[BTN_G]) begin
          buf_act_nx = GRAB;
          buf_cnt_nx = BUF_W'(BUF_FRAMES);
        end
      end else begin
        act_c      = (buf_cnt_q != '0) ? buf_act_q : button_action(btn_p0);
        state_nx   = act_c;
        index_nx   = (act_c == state_q) ? timer_step(state_q, index_q) : '0;
        buf_cnt_nx = '0;
      end
      pos_nx = place(pos_q, state_nx, other_p0);
    end
  end

  // Pipeline valids and the committed state; everything updates at once on commit
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      done_q    <= 1'b0;
      state_q   <= IDLE;
      index_q   <= '0;
      pos_q     <= POS_W'(START_POS);
      hp_q      <= HP_W'(MAX_HP);
      buf_act_q <= IDLE;
      buf_cnt_q <= '0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      done_q <= vld_p1;
      if (vld_p1) begin
        state_q   <= state_p1;
        index_q   <= index_p1;
        pos_q     <= pos_p1;
        hp_q      <= hp_p1;
        buf_act_q <= buf_act_p1;
        buf_cnt_q <= buf_cnt_p1;
      end
    end
  end

  // Data staging: sample inputs at the edge, then hold the computed next values
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      btn_p0     <= bus.player_buttons;
      other_p0   <= bus.other_player_position;
      opp_hit_p0 <= bus.opponent_attack_connected;
      own_hit_p0 <= bus.player_attack_connected;
      opp_ko_p0  <= bus.opponent_ko;
    end
    if (vld_p0) begin
      state_p1   <= state_nx;
      index_p1   <= index_nx;
      pos_p1     <= pos_nx;
      hp_p1      <= hp_nx;
      buf_act_p1 <= buf_act_nx;
      buf_cnt_p1 <= buf_cnt_nx;
    end
  end

  assign bus.state    = state_q;
  assign bus.index    = index_q;
  assign bus.position = pos_q;
  assign bus.health   = hp_q;
  assign bus.done_gen = done_q;
endmodule

// File: tb/tb_player_fsm_v2.sv
module tb_player_fsm_v2;
  import player_fsm_v2_pkg::*;

  logic sys_clk = 1'b0;
  logic reset;
  logic frame_clk;

  always #5 sys_clk = ~sys_clk;

  player_fsm_v2_if #(.POS_W(10), .TIMER_W(5), .HP_W(7)) bus0 ();
  player_fsm_v2_if #(.POS_W(10), .TIMER_W(5), .HP_W(7)) bus1 ();

  player_fsm_v2 #(.PLAYER_NUM(0), .START_POS(100)) dut0 (
    .sys_clk(sys_clk), .reset(reset), .frame_clk(frame_clk), .bus(bus0));
  player_fsm_v2 #(.PLAYER_NUM(1), .START_POS(574)) dut1 (
    .sys_clk(sys_clk), .reset(reset), .frame_clk(frame_clk), .bus(bus1));

  int chk = 0;
  int err = 0;

  // Reference model: one record per player
  int m_state[2], m_idx[2], m_pos[2], m_hp[2], m_buf_act[2], m_buf_left[2];
  int start_pos[2] = '{100, 574};

  function automatic int dur(input int s);
    if (s == int'(KICK)) return 12;
    if (s == int'(GRAB)) return 16;
    if (s == int'(HITSTUN)) return 10;
    return 1;
  endfunction

  function automatic int decode(input logic [4:0] b);
    if (b[0]) return int'(KICK);
    if (b[1]) return int'(BLOCK);
    if (b[2]) return int'(GRAB);
    if (b[3]) return int'(WALK_B);
    if (b[4]) return int'(WALK_F);
    return int'(IDLE);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_state[p] = int'(IDLE); m_idx[p] = 0; m_pos[p] = start_pos[p];
      m_hp[p] = 100; m_buf_act[p] = 0; m_buf_left[p] = 0;
    end
  endtask

  task automatic model_frame(input int p, input logic [4:0] b, input int oth, input logic hit, input logic ko);
    int s, mv, np, dir;
    s = m_state[p];
    if (s == int'(KO) || s == int'(WIN)) return;
    if (ko) begin
      m_state[p] = int'(WIN); m_idx[p] = 0; m_buf_left[p] = 0;
    end else if (hit && s != int'(BLOCK)) begin
      m_hp[p] = (m_hp[p] > 15) ? m_hp[p] - 15 : 0;
      m_state[p] = (m_hp[p] == 0) ? int'(KO) : int'(HITSTUN);
      m_idx[p] = 0; m_buf_left[p] = 0;
    end else if (hit) begin
      m_idx[p] = 0; m_buf_left[p] = 0;
    end else if (m_idx[p] < dur(s) - 1) begin
      m_idx[p]++;
      if (b[0]) begin m_buf_act[p] = int'(KICK); m_buf_left[p] = 4; end
      else if (b[2]) begin m_buf_act[p] = int'(GRAB); m_buf_left[p] = 4; end
      else if (m_buf_left[p] > 0) m_buf_left[p]--;
    end else begin
      m_state[p] = (m_buf_left[p] > 0) ? m_buf_act[p] : decode(b);
      m_idx[p] = 0; m_buf_left[p] = 0;
    end
    dir = (p == 0) ? 1 : -1;
    mv = 0;
    if (m_state[p] == int'(WALK_F)) mv = 4 * dir;
    if (m_state[p] == int'(WALK_B)) mv = -3 * dir;
    if (m_state[p] == int'(HITSTUN)) mv = -6 * dir;
    np = m_pos[p] + mv;
    if (np < 0) np = 0;
    if (np > 575) np = 575;
    if (p == 0 && np + 64 > oth) np = (oth - 64 < 0) ? 0 : oth - 64;
    if (p == 1 && np < oth + 64) np = oth + 64;
    m_pos[p] = np;
  endtask

  function automatic logic [25:0] obs(input int p);
    if (p == 0) return {bus0.state, bus0.index, bus0.position, bus0.health};
    return {bus1.state, bus1.index, bus1.position, bus1.health};
  endfunction

  function automatic logic [25:0] expv(input int p);
    return {4'(m_state[p]), 5'(m_idx[p]), 10'(m_pos[p]), 7'(m_hp[p])};
  endfunction

  task automatic drive_idle_inputs();
    bus0.player_buttons = '0; bus1.player_buttons = '0;
    bus0.other_player_position = 10'd600; bus1.other_player_position = 10'd0;
    bus0.opponent_attack_connected = 1'b0; bus1.opponent_attack_connected = 1'b0;
    bus0.player_attack_connected = 1'b0; bus1.player_attack_connected = 1'b0;
    bus0.opponent_ko = 1'b0; bus1.opponent_ko = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b0; frame_clk = 1'b0;
    drive_idle_inputs();
    repeat (2) @(negedge sys_clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge sys_clk);
  endtask

  // One frame: raise frame_clk, wait (bounded) for the commit pulse, advance the model
  task automatic do_frame(input logic [4:0] b0, input logic [4:0] b1, input int oth0, input int oth1,
                          input logic hit, input logic own, input logic ko);
    bit got;
    frame_clk = 1'b0;
    repeat (4) @(negedge sys_clk);
    bus0.player_buttons = b0; bus1.player_buttons = b1;
    bus0.other_player_position = oth0[9:0]; bus1.other_player_position = oth1[9:0];
    bus0.opponent_attack_connected = hit; bus1.opponent_attack_connected = hit;
    bus0.player_attack_connected = own; bus1.player_attack_connected = own;
    bus0.opponent_ko = ko; bus1.opponent_ko = ko;
    frame_clk = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge sys_clk);
      got = bus0.done_gen;
    end
    chk++;
    if (!got) begin
      err++;
      $display("FAIL frame_timeout: done_gen got 0 want 1 within 20 cycles");
    end
    model_frame(0, b0, oth0, hit, ko);
    model_frame(1, b1, oth1, hit, ko);
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    reset = 1'b0; frame_clk = 1'b0;
    drive_idle_inputs();
    repeat (3) @(negedge sys_clk);
    chk++;
    if (obs(0) !== {4'd0, 5'd0, 10'd100, 7'd100}) begin
      err++; $display("FAIL reset_p1: got %h want %h", obs(0), {4'd0, 5'd0, 10'd100, 7'd100});
    end
    chk++;
    if (obs(1) !== {4'd0, 5'd0, 10'd574, 7'd100}) begin
      err++; $display("FAIL reset_p2: got %h want %h", obs(1), {4'd0, 5'd0, 10'd574, 7'd100});
    end
    chk++;
    if ({bus0.done_gen, bus1.done_gen} !== 2'b00) begin
      err++; $display("FAIL reset_done: got %b want 00", {bus0.done_gen, bus1.done_gen});
    end
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_kick();
    do_reset();
    do_frame(5'b00001, 5'b00001, 600, 0, 1'b0, 1'b0, 1'b0);
    chk++;
    if ({bus0.state, bus0.index} !== {4'(KICK), 5'd0}) begin
      err++; $display("FAIL kick_start: got %h/%0d want %h/0", bus0.state, bus0.index, KICK);
    end
    chk++;
    if (bus1.done_gen !== 1'b1) begin
      err++; $display("FAIL kick_done_p2: got %b want 1", bus1.done_gen);
    end
    @(negedge sys_clk);
    chk++;
    if (bus0.done_gen !== 1'b0) begin
      err++; $display("FAIL done_pulse_width: got %b want 0 one cycle later", bus0.done_gen);
    end
    for (int f = 2; f <= 13; f++) begin
      do_frame(5'b00000, 5'b00000, 600, 0, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 2; p++) begin
        chk++;
        if (obs(p) !== expv(p)) begin
          err++; $display("FAIL kick_frame%0d_p%0d: got %h want %h", f, p, obs(p), expv(p));
        end
      end
      if (f == 12) begin
        chk++;
        if (bus0.index !== 5'd11) begin
          err++; $display("FAIL kick_index11: got %0d want 11", bus0.index);
        end
      end
    end
    chk++;
    if (bus0.state !== 4'(IDLE)) begin
      err++; $display("FAIL kick_end_idle: got %h want %h", bus0.state, IDLE);
    end
  endtask

  task automatic test_walk();
    do_reset();
    for (int f = 0; f < 10; f++) begin
      do_frame(5'b10000, 5'b10000, 600, 0, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 2; p++) begin
        chk++;
        if (obs(p) !== expv(p)) begin
          err++; $display("FAIL walk_f%0d_p%0d: got %h want %h", f, p, obs(p), expv(p));
        end
      end
    end
    chk++;
    if (bus0.position !== 10'd140) begin
      err++; $display("FAIL walk_140: got %0d want 140", bus0.position);
    end
    do_reset();
    for (int f = 0; f < 10; f++) do_frame(5'b10000, 5'b10000, 150, 0, 1'b0, 1'b0, 1'b0);
    chk++;
    if (bus0.position !== 10'd86) begin
      err++; $display("FAIL collide_86: got %0d want 86", bus0.position);
    end
    chk++;
    if (obs(1) !== expv(1)) begin
      err++; $display("FAIL collide_p2: got %h want %h", obs(1), expv(1));
    end
  endtask

  task automatic test_clamp();
    do_reset();
    for (int f = 0; f < 40; f++) begin
      do_frame(5'b01000, 5'b01000, 600, 0, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 2; p++) begin
        chk++;
        if (obs(p) !== expv(p)) begin
          err++; $display("FAIL clamp_f%0d_p%0d: got %h want %h", f, p, obs(p), expv(p));
        end
      end
    end
    chk++;
    if (bus0.position !== 10'd0) begin
      err++; $display("FAIL clamp_low: got %0d want 0", bus0.position);
    end
    chk++;
    if (bus1.position !== 10'd575) begin
      err++; $display("FAIL clamp_high: got %0d want 575", bus1.position);
    end
  endtask

  task automatic test_hits();
    int exp_hp;
    do_reset();
    exp_hp = 100;
    for (int h = 1; h <= 10 && exp_hp > 0; h++) begin
      do_frame(5'b00000, 5'b00000, 600, 0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      exp_hp = (exp_hp > 15) ? exp_hp - 15 : 0;
      chk++;
      if ({bus0.health, bus0.state} !== {7'(exp_hp), (exp_hp == 0) ? 4'(KO) : 4'(HITSTUN)}) begin
        err++; $display("FAIL hit%0d: got hp %0d st %h want hp %0d", h, bus0.health, bus0.state, exp_hp);
      end
      chk++;
      if (obs(1) !== expv(1)) begin
        err++; $display("FAIL hit%0d_p2: got %h want %h", h, obs(1), expv(1));
      end
    end
    do_frame(5'b00001, 5'b00001, 600, 0, 1'b1, 1'b0, 1'b0);
    chk++;
    if ({bus0.state, bus0.health} !== {4'(KO), 7'd0}) begin
      err++; $display("FAIL ko_persist: got st %h hp %0d want %h/0", bus0.state, bus0.health, KO);
    end
  endtask

  task automatic test_buffer();
    do_reset();
    do_frame(5'b00001, 5'b00001, 600, 0, 1'b0, 1'b0, 1'b0);
    repeat (9) do_frame(5'b00000, 5'b00000, 600, 0, 1'b0, 1'b0, 1'b0);
    do_frame(5'b00100, 5'b00100, 600, 0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 6 && bus0.state === 4'(KICK); f++)
      do_frame(5'b00000, 5'b00000, 600, 0, 1'b0, 1'b0, 1'b0);
    chk++;
    if ({bus0.state, bus0.index} !== {4'(GRAB), 5'd0}) begin
      err++; $display("FAIL buf_grab: got %h/%0d want %h/0", bus0.state, bus0.index, GRAB);
    end
    do_reset();
    do_frame(5'b00001, 5'b00001, 600, 0, 1'b0, 1'b0, 1'b0);
    repeat (6) do_frame(5'b00000, 5'b00000, 600, 0, 1'b0, 1'b0, 1'b0);
    do_frame(5'b00100, 5'b00100, 600, 0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 8 && bus0.state === 4'(KICK); f++)
      do_frame(5'b00000, 5'b00000, 600, 0, 1'b0, 1'b0, 1'b0);
    chk++;
    if (bus0.state !== 4'(IDLE)) begin
      err++; $display("FAIL buf_expired: got %h want %h", bus0.state, IDLE);
    end
    chk++;
    if (obs(1) !== expv(1)) begin
      err++; $display("FAIL buf_p2: got %h want %h", obs(1), expv(1));
    end
  endtask

  task automatic test_block_win();
    do_reset();
    do_frame(5'b00010, 5'b00010, 600, 0, 1'b0, 1'b0, 1'b0);
    do_frame(5'b00000, 5'b00000, 600, 0, 1'b1, 1'b1, 1'b0);
    chk++;
    if ({bus0.state, bus0.health} !== {4'(BLOCK), 7'd100}) begin
      err++; $display("FAIL block_hit: got st %h hp %0d want %h/100", bus0.state, bus0.health, BLOCK);
    end
    do_frame(5'b00000, 5'b00000, 600, 0, 1'b0, 1'b0, 1'b1);
    do_frame(5'b00001, 5'b00001, 600, 0, 1'b1, 1'b0, 1'b0);
    chk++;
    if ({bus0.state, bus0.health} !== {4'(WIN), 7'd100}) begin
      err++; $display("FAIL win_hold: got st %h hp %0d want %h/100", bus0.state, bus0.health, WIN);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 150; f++) begin
      logic [4:0] b0, b1;
      logic hit, ko;
      b0 = 5'($urandom_range(0, 31));
      b1 = 5'($urandom_range(0, 31));
      hit = ($urandom_range(0, 7) == 0);
      ko = ($urandom_range(0, 63) == 0);
      do_frame(b0, b1, 200 + int'($urandom_range(0, 420)), int'($urandom_range(0, 380)),
               hit, 1'($urandom_range(0, 1)), ko);
      for (int p = 0; p < 2; p++) begin
        chk++;
        if (obs(p) !== expv(p)) begin
          err++; $display("FAIL rand_f%0d_p%0d: got %h want %h", f, p, obs(p), expv(p));
        end
      end
      if (m_state[0] == int'(KO) || m_state[0] == int'(WIN) || m_state[1] == int'(KO)) do_reset();
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    do_frame(5'b00001, 5'b00001, 600, 0, 1'b0, 1'b0, 1'b0);
    frame_clk = 1'b0;
    repeat (4) @(negedge sys_clk);
    frame_clk = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;
    #1;
    chk++;
    if ({obs(0), bus0.done_gen} !== {4'd0, 5'd0, 10'd100, 7'd100, 1'b0}) begin
      err++; $display("FAIL reset_mid: got %h done %b want %h done 0", obs(0), bus0.done_gen,
                      {4'd0, 5'd0, 10'd100, 7'd100});
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge sys_clk);
    reset = 1'b1;
    model_reset();
    pulses = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (bus0.done_gen === 1'b1) pulses++;
    end
    chk++;
    if (pulses != 0) begin
      err++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", pulses);
    end
  endtask

  initial begin
    reset = 1'b0;
    frame_clk = 1'b0;
    test_reset();
    test_kick();
    test_walk();
    test_clamp();
    test_hits();
    test_buffer();
    test_block_win();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
